// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-event signals of keypad_scanner, bundled for port hookup.
// master = the scanner, slave = the keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input col_n, output row_n, key_code, key_valid, key_held);
  modport slave  (output col_n, input row_n, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-row debounce and a held/release tracker.
// Define KEYPAD_REPEAT_EN to build auto-repeat pulses while a key stays held.
module keypad_scanner #(
  parameter int unsigned SCAN_TICKS     = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  keypad_scanner_if.master kp
);

  if (SCAN_TICKS < 2 || SCAN_TICKS > 65535) begin : g_bad_scan_ticks
    $error("SCAN_TICKS out of range 2..65535");
  end
  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
    $error("DEBOUNCE_SCANS out of range 1..15");
  end
  if (REPEAT_SCANS < 1 || REPEAT_SCANS > 65535) begin : g_bad_repeat
    $error("REPEAT_SCANS out of range 1..65535");
  end

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_e;

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_sync1, r_csync;
  logic [15:0] r_tick_cnt;
  logic [1:0]  r_row, w_row_nxt;
  logic [1:0]  r_col, w_col_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_key_code, w_code_nxt;
  logic        r_key_valid, w_valid_nxt;
  logic        r_key_held, w_held_nxt;
`ifdef KEYPAD_REPEAT_EN
  logic [15:0] r_rep, w_rep_nxt, w_rep_inc;
`endif

  logic        w_tick;
  logic        w_single;
  logic [1:0]  w_col;
  logic [3:0]  w_cnt_inc;
  logic        w_accept;
  logic [3:0]  w_row_n;

  assign w_tick    = (r_tick_cnt == 16'(SCAN_TICKS - 1));
  assign w_cnt_inc = r_cnt + 4'd1;
`ifdef KEYPAD_REPEAT_EN
  assign w_rep_inc = r_rep + 16'd1;
`endif

  // Exactly one column low identifies a candidate key; anything else is noise or ghosting.
  always_comb begin
    w_single = 1'b1;
    w_col    = 2'd0;
    unique case (r_csync)
      4'b1110: w_col = 2'd0;
      4'b1101: w_col = 2'd1;
      4'b1011: w_col = 2'd2;
      4'b0111: w_col = 2'd3;
      default: w_single = 1'b0;
    endcase
  end

  function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0: map_key = 4'h1;  4'h1: map_key = 4'h2;  4'h2: map_key = 4'h3;  4'h3: map_key = 4'hA;
      4'h4: map_key = 4'h4;  4'h5: map_key = 4'h5;  4'h6: map_key = 4'h6;  4'h7: map_key = 4'hB;
      4'h8: map_key = 4'h7;  4'h9: map_key = 4'h8;  4'hA: map_key = 4'h9;  4'hB: map_key = 4'hC;
      4'hC: map_key = 4'hE;  4'hD: map_key = 4'h0;  4'hE: map_key = 4'hF;  default: map_key = 4'hD;
    endcase
  endfunction

  // NOTE: every signal gets a default before the case so no path leaves it unassigned,
  // which is what keeps a combinational block from inferring a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_key_code;
    w_valid_nxt = 1'b0;
    w_held_nxt  = r_key_held;
    w_accept    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rep_nxt   = r_rep;
`endif
    case (r_state)
      ST_SCAN: if (w_tick) begin
        if (w_single) begin
          w_col_nxt = w_col;
          w_cnt_nxt = 4'd1;
          if (DEBOUNCE_SCANS == 1) w_accept = 1'b1;
          else                     w_state_nxt = ST_DEBOUNCE;
        end else begin
          w_row_nxt = r_row + 2'd1;
        end
      end
      ST_DEBOUNCE: if (w_tick) begin
        if (w_single && (w_col == r_col)) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == 4'(DEBOUNCE_SCANS)) w_accept = 1'b1;
        end else begin
          w_cnt_nxt   = 4'd0;
          w_row_nxt   = r_row + 2'd1;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_HELD: if (w_tick) begin
        if (r_csync == 4'b1111) begin
          if (w_cnt_inc == 4'(DEBOUNCE_SCANS)) begin
            w_held_nxt  = 1'b0;
            w_cnt_nxt   = 4'd0;
            w_row_nxt   = r_row + 2'd1;
            w_state_nxt = ST_SCAN;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_cnt_nxt = 4'd0;
        end
`ifdef KEYPAD_REPEAT_EN
        if (!r_csync[r_col]) begin
          if (w_rep_inc == 16'(REPEAT_SCANS)) begin
            w_valid_nxt = 1'b1;
            w_rep_nxt   = 16'd0;
          end else begin
            w_rep_nxt = w_rep_inc;
          end
        end
`endif
      end
      default: w_state_nxt = ST_SCAN;
    endcase

    if (w_accept) begin
      w_code_nxt  = map_key(r_row, w_col);
      w_valid_nxt = 1'b1;
      w_held_nxt  = 1'b1;
      w_cnt_nxt   = 4'd0;
      w_state_nxt = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
      w_rep_nxt   = 16'd0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 4'b1111;
      r_csync     <= 4'b1111;
      r_tick_cnt  <= 16'd0;
      r_state     <= ST_SCAN;
      r_row       <= 2'd0;
      r_col       <= 2'd0;
      r_cnt       <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep       <= 16'd0;
`endif
    end else begin
      r_sync1     <= kp.col_n;
      r_csync     <= r_sync1;
      r_tick_cnt  <= w_tick ? 16'd0 : r_tick_cnt + 16'd1;
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_held  <= w_held_nxt;
`ifdef KEYPAD_REPEAT_EN
      r_rep       <= w_rep_nxt;
`endif
    end
  end

  always_comb begin
    w_row_n        = 4'b1111;
    w_row_n[r_row] = 1'b0;
  end

  assign kp.row_n     = w_row_n;
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: per-sample stimulus (directed then random) checked every
// cycle against a sample-level keypad behaviour model.
`timescale 1ns/1ps
module tb_keypad_scanner;
  localparam int SCAN_TICKS = 4;
  localparam int DEB        = 3;
  localparam int REP        = 2;
  localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'hE, 4'h0, 4'hF, 4'hD};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kp ();
  keypad_scanner #(.SCAN_TICKS(SCAN_TICKS), .DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(REP))
    dut (.clk(clk), .rst_n(rst_n), .kp(kp));

  int n_checks = 0;
  int n_errors = 0;

  // Model: which row is being looked at, whether a key is held, and run lengths of samples.
  int         m_row;
  bit         m_held;
  logic [3:0] m_code;
  bit         m_pulse;
  logic [3:0] run_pat;
  int         run_len, rel_len, rep_len, held_col;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int low_col(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (!p[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_row = 0; m_held = 0; m_code = 4'h0; m_pulse = 0;
    run_pat = 4'hF; run_len = 0; rel_len = 0; rep_len = 0; held_col = 0;
  endtask

  task automatic model_sample(input logic [3:0] s);
    m_pulse = 0;
    if (!m_held) begin
      if (run_len > 0) begin
        if (s == run_pat) run_len++;
        else begin run_len = 0; m_row = (m_row + 1) % 4; end
      end else if ($countones(~s) == 1) begin
        run_pat = s; run_len = 1;
      end else begin
        m_row = (m_row + 1) % 4;
      end
      if (run_len == DEB) begin
        held_col = low_col(run_pat);
        m_code   = KEYMAP[m_row * 4 + held_col];
        m_pulse  = 1; m_held = 1;
        run_len  = 0; rel_len = 0; rep_len = 0;
      end
    end else begin
      rel_len = (s == 4'hF) ? rel_len + 1 : 0;
`ifdef KEYPAD_REPEAT_EN
      if (!s[held_col]) begin
        rep_len++;
        if (rep_len == REP) begin m_pulse = 1; rep_len = 0; end
      end
`endif
      if (rel_len == DEB) begin
        m_held = 0; rel_len = 0; m_row = (m_row + 1) % 4;
      end
    end
  endtask

  // Hold one column pattern for a full row slot; the slot's last edge is the sampling tick.
  task automatic apply_sample(input logic [3:0] s);
    logic [3:0] exp_row;
    kp.col_n = s;
    for (int c = 1; c <= SCAN_TICKS; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == SCAN_TICKS) model_sample(s);
      exp_row = 4'hF;
      exp_row[m_row] = 1'b0;
      check("row_n", kp.row_n, exp_row);
      check("key_valid", {3'b0, kp.key_valid}, {3'b0, (c == SCAN_TICKS) && m_pulse});
      check("key_held", {3'b0, kp.key_held}, {3'b0, m_held});
      check("key_code", kp.key_code, m_code);
    end
  endtask

  task automatic apply_run(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) apply_sample(s);
  endtask

  task automatic idle_until_row(input int r);
    for (int i = 0; i < 4 && m_row != r; i++) apply_sample(4'hF);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_row_n", kp.row_n, 4'b1110);
    check("rst_valid", {3'b0, kp.key_valid}, 4'h0);
    check("rst_held", {3'b0, kp.key_held}, 4'h0);
    check("rst_code", kp.key_code, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] p;
    int a;
    kp.col_n = 4'hF;
    model_reset();
    pulse_reset();

    // Idle rotation through all rows and back to row 0.
    apply_run(4'hF, 5);

    // Key '5': column 1 on row 1, held past acceptance.
    idle_until_row(1);
    apply_run(4'b1101, 3);
    check("press5_code", kp.key_code, 4'h5);
    check("press5_held", {3'b0, kp.key_held}, 4'h1);
    check("press5_row", kp.row_n, 4'b1101);
    apply_run(4'b1101, 2);

    // Release with a glitch on the second sample: five samples until key_held drops.
    apply_sample(4'hF);
    apply_sample(4'b1101);
    apply_run(4'hF, 2);
    check("glitch_still_held", {3'b0, kp.key_held}, 4'h1);
    apply_sample(4'hF);
    check("release_held", {3'b0, kp.key_held}, 4'h0);

    // One-sample bounce, then a two-column ghost pattern.
    apply_sample(4'b1110);
    apply_run(4'hF, 2);
    apply_run(4'b1100, 4);

    // '#' on row 3, held long enough to see repeats when built in.
    idle_until_row(3);
    apply_run(4'b1011, 7);
    check("hash_code", kp.key_code, 4'hF);
    apply_run(4'hF, 3);

    // Reset while debouncing: the candidate must vanish.
    apply_run(4'b0111, 2);
    kp.col_n = 4'hF;
    pulse_reset();
    apply_run(4'hF, 4);

    // Reset while held.
    apply_run(4'b1110, 3);
    check("pre_reset_held", {3'b0, kp.key_held}, 4'h1);
    kp.col_n = 4'hF;
    pulse_reset();
    apply_run(4'hF, 4);

    // Random runs of idle, single-column and multi-column patterns.
    for (int k = 0; k < 200; k++) begin
      a = $urandom_range(0, 9);
      p = 4'hF;
      if (a >= 4 && a <= 7) begin
        p[$urandom_range(0, 3)] = 1'b0;
      end else if (a >= 8) begin
        a = $urandom_range(0, 3);
        p[a] = 1'b0;
        p[(a + 1 + $urandom_range(0, 2)) % 4] = 1'b0;
        if ($urandom_range(0, 1) == 1) p[$urandom_range(0, 3)] = 1'b0;
      end
      apply_run(p, $urandom_range(1, 5));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
